// File: rtl/mcpu_pkg.sv
// Shared definitions for the MIPS pipeline front end: fetch FSM encoding,
// decode-bound word width and the default reset PC.
package mcpu_pkg;

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StHold
    } fetch_state_e;

    localparam int unsigned ID_DATA_W = 62;

    // Word address of byte 0x3000.
    localparam logic [31:2] RESET_PC_DEF = 30'h0C00;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry skid buffer that parks a returning instruction word while decode
// is stalled. Clear wins over load, and load wins over drain.
module if_hold_buf
    import mcpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 drain,
    input  logic                 clear,
    input  logic [ID_DATA_W-1:0] din,
    output logic [ID_DATA_W-1:0] dout,
    output logic                 full
);

    logic [ID_DATA_W-1:0] data_q;
    logic                 full_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (clear) begin
            full_q <= 1'b0;
        end else if (load) begin
            data_q <= din;
            full_q <= 1'b1;
        end else if (drain) begin
            full_q <= 1'b0;
        end
    end

    assign dout = data_q;
    assign full = full_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, hold buffer.
// Define IF_DELAY_SLOT_EN for MIPS delay-slot redirects; otherwise redirects kill.
module if_fetch
    import mcpu_pkg::*;
#(
    parameter logic [31:2] RESET_PC = RESET_PC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IF_STALL,
    input  logic                 IF_FLUSH,
    input  logic                 i_redirect,
    input  logic [31:2]          i_NPC,
    output logic                 im_req,
    output logic [31:2]          im_addr,
    input  logic                 im_rvalid,
    input  logic [31:0]          im_rdata,
    output logic [ID_DATA_W-1:0] o_ID_DATA,
    output logic                 o_ID_VALID
);

    fetch_state_e         state_q, state_d;
    logic [31:2]          pc_q, pc_d, pc_inc, next_pc, fetch_addr;
    logic [31:2]          pend_npc_q, pend_npc_d;
    logic                 pend_valid_q, pend_valid_d;
    logic                 kill_q, kill_redir;
    logic                 redir, accept, rsp, live;
    logic                 take, park, drop, drain, issue_fetch;
    logic [ID_DATA_W-1:0] hold_data;
    logic                 hold_full;

    assign redir  = i_redirect && !IF_STALL;
    assign accept = !IF_STALL && !IF_FLUSH;
    assign pc_inc = pc_q + 30'd1;

    // A redirect on this edge bypasses the pending register so the fetch after
    // the in-flight word already goes to the target.
    assign next_pc    = redir ? i_NPC : (pend_valid_q ? pend_npc_q : pc_inc);
    assign fetch_addr = pend_valid_q ? pend_npc_q : pc_q;

`ifdef IF_DELAY_SLOT_EN
    assign kill_redir = 1'b0;
    assign kill_q     = 1'b0;
`else
    assign kill_redir = redir;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kill_q <= 1'b0;
        end else if (state_q == StWait && kill_redir && !im_rvalid) begin
            kill_q <= 1'b1;
        end else if (drop) begin
            kill_q <= 1'b0;
        end
    end
`endif

    assign rsp         = (state_q == StWait) && im_rvalid;
    assign live        = rsp && !kill_q && !kill_redir;
    assign take        = live && accept;
    assign park        = live && !accept;
    assign drop        = rsp && (kill_q || kill_redir);
    assign drain       = (state_q == StHold) && accept && !kill_redir;
    assign issue_fetch = (state_q == StFetch) && !kill_redir;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: if (issue_fetch) state_d = StWait;
            StWait: begin
                if (drop) begin
                    state_d = StFetch;
                end else if (park) begin
                    state_d = StHold;
                end
            end
            StHold:  if (drain || kill_redir) state_d = StFetch;
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        im_req  = 1'b0;
        im_addr = pc_q;
        unique case (state_q)
            StFetch: begin
                im_req  = rst && issue_fetch;
                im_addr = fetch_addr;
            end
            StWait: begin
                im_req  = rst && take;
                im_addr = take ? next_pc : pc_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_npc_d   = pend_npc_q;
        if (issue_fetch) begin
            pc_d = fetch_addr;
        end else if (take || drain) begin
            pc_d = next_pc;
        end
        if (redir && !(take || drain)) begin
            pend_valid_d = 1'b1;
            pend_npc_d   = i_NPC;
        end else if (take || drain || issue_fetch) begin
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_npc_q   <= '0;
        end else begin
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_npc_q   <= pend_npc_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_ID_DATA  <= '0;
            o_ID_VALID <= 1'b0;
        end else if (kill_redir) begin
            o_ID_VALID <= 1'b0;
        end else if (take) begin
            o_ID_DATA  <= {pc_inc, im_rdata};
            o_ID_VALID <= 1'b1;
        end else if (drain) begin
            o_ID_DATA  <= hold_data;
            o_ID_VALID <= 1'b1;
        end else if (!IF_STALL) begin
            o_ID_VALID <= 1'b0;
        end
    end

    if_hold_buf u_hold_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (park),
        .drain (drain),
        .clear (kill_redir),
        .din   ({pc_inc, im_rdata}),
        .dout  (hold_data),
        .full  (hold_full)
    );

    // A response is only legal while a request is outstanding.
    assert property (@(posedge clk) disable iff (!rst) im_rvalid |-> state_q == StWait);
    assert property (@(posedge clk) disable iff (!rst) state_q == StHold |-> hold_full);

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the 5-stage MIPS pipeline. Produces the 62-bit `{PC+1[31:2], instr[31:0]}` word that the decode stage consumes. Takes back the decode stage's resolved next-PC as a redirect. Owns the PC register, a single-outstanding-request handshake to instruction memory, and a one-entry hold buffer so returning instructions survive decode stalls.

## Interface
Parameters:
- `RESET_PC` — default `30'h0C00` (byte address `0x3000`). Word PC loaded at reset.

Ports:
- `clk` — in, 1 — pipeline clock; all state on rising edge.
- `rst` — in, 1 — one clock; reset is asynchronous and active-low.
- `IF_STALL` — in, 1 — decode cannot accept; hold the output register.
- `IF_FLUSH` — in, 1 — squash the instruction offered to decode (bubble).
- `i_redirect` — in, 1 — decode resolved a taken jump or branch.
- `i_NPC` — in, [31:2] — redirect target word address.
- `im_req` — out, 1 — fetch request, valid for one cycle per request.
- `im_addr` — out, [31:2] — fetch word address.
- `im_rvalid` — in, 1 — response valid; at least 1 cycle after the request edge.
- `im_rdata` — in, 32 — instruction word.
- `o_ID_DATA` — out reg, 62 — `{PCP1, instr}` to decode.
- `o_ID_VALID` — out reg, 1 — `o_ID_DATA` holds a live instruction.

## Operation
- FSM states:
  - FETCH: drive `im_req=1`, `im_addr=pc` → WAIT.
  - WAIT: wait for `im_rvalid`.
  - HOLD: response captured in the hold buffer while stalled.
- WAIT with `im_rvalid` and accept (`!IF_STALL`):
  - Load `o_ID_DATA <= {pc+1, im_rdata}` and set `o_ID_VALID <= 1`.
  - `pc <= next_pc`.
  - In the same cycle, assert `im_req` with `im_addr=next_pc` and stay in WAIT (back-to-back).
- WAIT with `im_rvalid` and `IF_STALL`: capture `{pc+1, im_rdata}` into the hold buffer → HOLD.
- HOLD when `!IF_STALL`: move the buffer into `o_ID_DATA`, set `o_ID_VALID=1`, advance `pc` → FETCH.
- `next_pc` is `pend_npc` if `pend_valid`, else `pc+1`. `pc+1` is 30-bit and wraps from `3FFF_FFFF` to 0.
- A redirect is sampled only on an edge with `i_redirect && !IF_STALL`:
  - Sets `pend_valid` and `pend_npc <= i_NPC`.
  - `pend_valid` clears when `pend_npc` is issued on `im_req`.
  - A second redirect overwrites the first.
- `IF_FLUSH` (with `!IF_STALL`): `o_ID_VALID <= 0`; `o_ID_DATA` is unchanged. The hold buffer and `pc` are not affected by the flush alone.
- Priority: `rst` > redirect effect > `IF_FLUSH` > `IF_STALL`. `IF_STALL` held high freezes `o_ID_DATA` and `o_ID_VALID` exactly.
- One request outstanding at most. `im_rvalid` outside WAIT is a protocol error; it is ignored and flagged by an assertion in simulation.

## Timing
- Reset values:
  - `pc=RESET_PC`, state FETCH.
  - `o_ID_DATA=0`, `o_ID_VALID=0`.
  - `im_req=0` while `rst` is low.
  - `pend_valid=0`, hold buffer empty.
- First `im_req` is in the first cycle after `rst` deasserts.
- With 1-cycle memory: first `o_ID_VALID` is 2 edges after reset release. Steady state is 1 instruction per cycle.
- Redirect penalty:
  - Delay-slot build: 0 bubbles after the slot.
  - No-slot build: 1 bubble plus the memory latency.
- `rst` asserted mid-request: the FSM returns to FETCH. Instruction memory shares `rst`, so no stale response arrives.

## Configuration
- `IF_DELAY_SLOT_EN`, defined: MIPS branch delay slot.
  - The instruction in flight or held when a redirect is sampled is delivered normally.
  - `pend_npc` is used for the fetch after it.
- `IF_DELAY_SLOT_EN`, undefined:
  - A redirect kills the in-flight response (`kill` flag: `im_rvalid` consumed, not delivered).
  - A redirect clears the hold buffer.
  - `o_ID_VALID <= 0` on that edge.
  - The next request uses `i_NPC`.

## Structure
- Shared package `mcpu_pkg`:
  - Fetch FSM state enum (FETCH/WAIT/HOLD).
  - `ID_DATA_W=62`.
  - `RESET_PC` default constant.
- One sub-module `if_hold_buf`: one-entry 62-bit skid buffer with load/drain/clear and a `full` flag.
- PC, pending-redirect and FSM logic stay in `if_fetch`.

## Test plan
- Reset release, 1-cycle memory returning `0x2408_0005` at word `0x0C00`:
  - `im_addr=0x0C00` in cycle 1.
  - `o_ID_DATA={0x0C01, 0x24080005}` and valid at edge 2.
  - Then addresses `0x0C01`, `0x0C02` back-to-back.
- `IF_STALL` high for 3 cycles while a response arrives:
  - Output frozen for those 3 cycles.
  - The held instruction appears on the edge after the stall drops.
  - No request is issued during HOLD.
- Redirect `i_NPC=0x0D00` sampled while the word at `0x0C05` is in flight:
  - Slot build: `0x0C05` delivered, then `im_addr=0x0D00`.
  - No-slot build: `0x0C05` never valid, then `im_addr=0x0D00`.
- `IF_FLUSH` for one cycle: `o_ID_VALID=0` for one edge; the next sequential instruction is not lost.
- 3-cycle memory latency with `rst` pulsed low mid-WAIT: outputs return to reset values immediately; the first request after release is to `0x0C00`.
- Two redirects on consecutive unstalled edges (`0x0D00`, then `0x0E00`): the next issued address is `0x0E00`.
